bram_sync_fifo: RTL and testbench
=================================

BRAM_SYNC_FIFO -- requirements
Module: bram_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH SHALL be: default 4, word width in bits.
REQ-002 Parameter ADDRESS_WIDTH SHALL be: default 4, pointer width; DEPTH = 2**ADDRESS_WIDTH words.
REQ-003 Parameter AFULL_LEVEL SHALL be: default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 Parameter AEMPTY_LEVEL SHALL be: default 2, almost_empty threshold (1..DEPTH-1).
REQ-005 The block SHALL use one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-006 Port clk SHALL be: input, 1, rising-edge clock for all state.
REQ-007 Port rst_n SHALL be: input, 1, asynchronous active-low reset.
REQ-008 Port cs SHALL be: input, 1, chip select; when 0, wr_en and rd_en are ignored.
REQ-009 Port wr_en SHALL be: input, 1, write request.
REQ-010 Port din SHALL be: input, DATA_WIDTH, write data.
REQ-011 Port rd_en SHALL be: input, 1, read request.
REQ-012 Port dout SHALL be: output, DATA_WIDTH, registered read data.
REQ-013 Port dout_valid SHALL be: output, 1, one-cycle pulse; dout holds a newly popped word.
REQ-014 Port full SHALL be: output, 1, count == DEPTH.
REQ-015 Port empty SHALL be: output, 1, count == 0.
REQ-016 Port almost_full SHALL be: output, 1, count >= AFULL_LEVEL.
REQ-017 Port almost_empty SHALL be: output, 1, count <= AEMPTY_LEVEL.
REQ-018 Port count SHALL be: output, ADDRESS_WIDTH+1, current occupancy 0..DEPTH.
REQ-019 Port overflow SHALL be: output, 1, one-cycle pulse on a rejected write.
REQ-020 Port underflow SHALL be: output, 1, one-cycle pulse on a rejected read.

Function
REQ-021 Storage SHALL be a DEPTH x DATA_WIDTH simple dual-port array; one write port and one read port, both synchronous to clk; contents are not reset.
REQ-022 A write SHALL be accepted iff cs && wr_en && !full, with full sampled before the edge; the write stores din at wr_ptr and increments wr_ptr.
REQ-023 A read SHALL be accepted iff cs && rd_en && !empty, with empty sampled before the edge; the read loads mem[rd_ptr] into dout at the same edge, asserts dout_valid for that following cycle, and increments rd_ptr.
REQ-024 Read latency SHALL be 1 cycle from the accepting edge; dout SHALL hold its last value when no read is accepted.
REQ-025 wr_ptr and rd_ptr SHALL be ADDRESS_WIDTH+1 bits, wrapping modulo 2*DEPTH; the low ADDRESS_WIDTH bits address memory.
REQ-026 count SHALL be: +1 on write only; -1 on read only; unchanged on both or neither; it never leaves 0..DEPTH.
REQ-027 Simultaneous write and read with 0 < count < DEPTH SHALL both be accepted, and count SHALL be unchanged.
REQ-028 Both requested when empty: the write is accepted, the read is rejected (underflow=1), and count becomes 1; no write-to-read bypass.
REQ-029 Both requested when full: the read is accepted, the write is rejected (overflow=1), and count becomes DEPTH-1.
REQ-030 full, empty, almost_full, almost_empty SHALL be registered, derived from next-state count, and valid in the cycle after the edge.
REQ-031 overflow/underflow SHALL pulse for exactly one cycle per rejected request and SHALL NOT alter pointers, count or memory.

Reset
REQ-032 On rst_n=0, asynchronously: wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0.
REQ-033 Reset asserted mid-operation SHALL discard all stored words; the first read after release with no prior write SHALL underflow.
REQ-034 Requests present in the first edge after rst_n rises SHALL be processed normally.

Verification (DATA_WIDTH=4, ADDRESS_WIDTH=4, DEPTH=16, AFULL_LEVEL=14, AEMPTY_LEVEL=2)
REQ-035 Write 0x1,0x2,0x3, then read 3 times -> dout=0x1,0x2,0x3 each one cycle after its rd_en edge, with dout_valid high each; then empty=1, count=0.
REQ-036 Write 16 words 0x0..0xF, then a 17th write of 0x5 -> full=1 after the 16th, overflow pulses once on the 17th, and count stays 16; 16 reads return 0x0..0xF.
REQ-037 Write/read interleaved across 40 words -> pointers wrap; data order is preserved; almost_empty=1 at count<=2; almost_full=1 at count>=14.
REQ-038 With count=0, wr_en=rd_en=1 with din=0x9 -> underflow=1, count=1, dout unchanged; the next read returns 0x9.
REQ-039 With count=16, wr_en=rd_en=1 -> overflow=1, count=15, full=0, and dout = oldest word.
REQ-040 With count=5, pulse rst_n low between edges -> outputs reach the REQ-032 values immediately, without a clock; a read after release -> underflow=1.

Source files
------------

// File: rtl/bram_sync_fifo.sv
// Synchronous FIFO over a simple dual-port array with registered read data,
// registered status flags and one-cycle overflow/underflow pulses.
module bram_sync_fifo #(
  parameter int DATA_WIDTH    = 4,
  parameter int ADDRESS_WIDTH = 4,
  parameter int AFULL_LEVEL   = (2 ** ADDRESS_WIDTH) - 2,
  parameter int AEMPTY_LEVEL  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [ADDRESS_WIDTH:0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int CW    = ADDRESS_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         wr_ptr;
  logic [CW-1:0]         rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  wr_accept;
  logic                  rd_accept;

  // full/empty are the registered flags, so acceptance sees the pre-edge state.
  assign wr_accept = cs && wr_en && !full;
  assign rd_accept = cs && rd_en && !empty;

  always_comb begin
    count_next = count;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDRESS_WIDTH-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + CW'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + CW'(1);
        dout   <= mem[rd_ptr[ADDRESS_WIDTH-1:0]];
      end
      dout_valid   <= rd_accept;
      count        <= count_next;
      full         <= (count_next == DEPTH_CNT);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AFULL_CNT);
      almost_empty <= (count_next <= AEMPTY_CNT);
      overflow     <= cs && wr_en && full;
      underflow    <= cs && rd_en && empty;
    end
  end

endmodule

// File: tb/tb_bram_sync_fifo.sv
// Scoreboard bench for bram_sync_fifo: stimulus pushes expected read data,
// a negedge monitor pops and compares whenever dout_valid is seen.
module tb_bram_sync_fifo;

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic       wr_en;
  logic [3:0] din;
  logic       rd_en;
  logic [3:0] dout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  logic [3:0] model[$];
  logic [3:0] sb[$];

  bram_sync_fifo #(
    .DATA_WIDTH(4),
    .ADDRESS_WIDTH(4),
    .AFULL_LEVEL(14),
    .AEMPTY_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cs(cs),
    .wr_en(wr_en),
    .din(din),
    .rd_en(rd_en),
    .dout(dout),
    .dout_valid(dout_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one request cycle, advance the reference queue and check status after the edge.
  task automatic applyStimulus(input logic c, input logic w, input logic r, input logic [3:0] d);
    logic wr_ok, rd_ok, exp_ovf, exp_unf;
    cs    = c;
    wr_en = w;
    rd_en = r;
    din   = d;
    wr_ok   = c && w && (model.size() != 16);
    rd_ok   = c && r && (model.size() != 0);
    exp_ovf = c && w && !wr_ok;
    exp_unf = c && r && !rd_ok;
    if (rd_ok) sb.push_back(model.pop_front());
    if (wr_ok) model.push_back(d);
    @(posedge clk);
    #1;
    checkOutput("count", 32'(count), 32'(model.size()));
    checkOutput("full", 32'(full), 32'(model.size() == 16));
    checkOutput("empty", 32'(empty), 32'(model.size() == 0));
    checkOutput("almost_full", 32'(almost_full), 32'(model.size() >= 14));
    checkOutput("almost_empty", 32'(almost_empty), 32'(model.size() <= 2));
    checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
    checkOutput("underflow", 32'(underflow), 32'(exp_unf));
    cs    = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_count"}, 32'(count), 32'd0);
    checkOutput({tag, "_dout"}, 32'(dout), 32'd0);
    checkOutput({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    checkOutput({tag, "_full"}, 32'(full), 32'd0);
    checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
    checkOutput({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    checkOutput({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
    checkOutput({tag, "_underflow"}, 32'(underflow), 32'd0);
  endtask

  // Monitor: every dout_valid pulse must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_dout_valid: actual=0x%0h required=no_output at %0t", dout, $time);
      end else begin
        logic [3:0] exp_word;
        exp_word = sb.pop_front();
        if (dout !== exp_word) begin
          errors++;
          $display("[TB] FAIL dout: actual=0x%0h required=0x%0h at %0t", dout, exp_word, $time);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cs    = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 4'h0;
    #12;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic write 1,2,3 then read back");
    applyStimulus(1, 1, 0, 4'h1);
    applyStimulus(1, 1, 0, 4'h2);
    applyStimulus(1, 1, 0, 4'h3);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 4'h0);
    applyStimulus(1, 0, 0, 4'h0);
    checkOutput("drained_empty", 32'(empty), 32'd1);

    $display("[TB] write+read while empty");
    applyStimulus(1, 1, 1, 4'h9);
    checkOutput("dout_hold", 32'(dout), 32'h3);
    checkOutput("no_valid_on_underflow", 32'(dout_valid), 32'd0);
    applyStimulus(1, 0, 1, 4'h0);
    applyStimulus(1, 0, 0, 4'h0);

    $display("[TB] chip select low ignores requests");
    applyStimulus(0, 1, 1, 4'hA);
    applyStimulus(0, 1, 0, 4'hB);

    $display("[TB] fill to full, overflow, drain");
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 0, 4'(i));
    checkOutput("full_after_16", 32'(full), 32'd1);
    applyStimulus(1, 1, 0, 4'h5);
    checkOutput("count_after_17th", 32'(count), 32'd16);
    applyStimulus(1, 0, 0, 4'h0);
    checkOutput("overflow_single_pulse", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 1, 4'h0);
    applyStimulus(1, 0, 0, 4'h0);

    $display("[TB] write+read while full");
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 0, 4'(15 - i));
    applyStimulus(1, 1, 1, 4'h7);
    checkOutput("both_full_count", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) applyStimulus(1, 0, 1, 4'h0);
    applyStimulus(1, 0, 0, 4'h0);

    $display("[TB] interleaved traffic across 40 words");
    for (int i = 0; i < 14; i++) applyStimulus(1, 1, 0, 4'(i * 3 + 1));
    checkOutput("afull_at_14", 32'(almost_full), 32'd1);
    for (int i = 14; i < 40; i++) applyStimulus(1, 1, (i % 5) != 0, 4'(i * 3 + 1));
    while (model.size() > 0) applyStimulus(1, 0, 1, 4'h0);
    applyStimulus(1, 0, 0, 4'h0);

    $display("[TB] asynchronous reset with five stored words");
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 4'(i + 8));
    checkOutput("count_before_reset", 32'(count), 32'd5);
    rst_n = 1'b0;
    #2;
    checkReset("async_reset");
    rst_n = 1'b1;
    model.delete();
    applyStimulus(1, 0, 1, 4'h0);
    checkOutput("underflow_after_reset", 32'(underflow), 32'd1);
    applyStimulus(1, 1, 0, 4'hC);
    applyStimulus(1, 0, 1, 4'h0);
    applyStimulus(1, 0, 0, 4'h0);
    applyStimulus(1, 0, 0, 4'h0);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
